// File: rtl/fir_mac_filter_if.sv
// Sample/result handshakes and coefficient write port of the time-multiplexed FIR.
// AW must equal $clog2(TAPS) of the attached filter.
interface fir_mac_filter_if #(
  parameter int N  = 32,
  parameter int AW = 3
);
  logic                 coef_wr;
  logic [AW-1:0]        coef_addr;
  logic signed [N-1:0]  coef_data;
  logic                 x_valid;
  logic                 x_ready;
  logic signed [N-1:0]  x_in;
  logic                 y_valid;
  logic                 y_ready;
  logic signed [N-1:0]  y_out;

  modport master (
    output coef_wr, coef_addr, coef_data, x_valid, x_in, y_ready,
    input  x_ready, y_valid, y_out
  );
  modport slave (
    input  coef_wr, coef_addr, coef_data, x_valid, x_in, y_ready,
    output x_ready, y_valid, y_out
  );
endinterface

// File: rtl/fir_mac_filter.sv
// TAPS-deep FIR using one shared MAC iterated over all taps per accepted sample.
// Sample in / result out via valid-ready; coefficients writable only while idle.
module fir_mac_filter #(
  parameter int N     = 32,
  parameter int TAPS  = 8,
  parameter int SHIFT = 0,
  localparam int ACC_W = 2*N + $clog2(TAPS),
  localparam int AW    = $clog2(TAPS)
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic clr,
  fir_mac_filter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                  state, state_nxt;
  logic signed [N-1:0]     d [TAPS];
  logic signed [N-1:0]     c [TAPS];
  logic signed [ACC_W-1:0] acc, sum_nxt;
  logic signed [2*N-1:0]   prod;
  logic [AW-1:0]           k;
  logic signed [N-1:0]     y_q;
  logic                    accept, coef_ok, last;

  // Arithmetic shift then clamp to the N-bit signed range.
  function automatic logic signed [N-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if ((&s[ACC_W-1:N-1]) || !(|s[ACC_W-1:N-1]))
      return s[N-1:0];
    return s[ACC_W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction

  assign prod    = (2*N)'(d[k]) * (2*N)'(c[k]);
  assign sum_nxt = acc + ACC_W'(prod);
  assign last    = (k == AW'(TAPS-1));
  assign accept  = ena && bus.x_valid && (state == IDLE);
  assign coef_ok = ena && bus.coef_wr && (state == IDLE) &&
                   ({1'b0, bus.coef_addr} < (AW+1)'(TAPS));
  assign bus.y_out = y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.x_ready = 1'b0;
    bus.y_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.x_ready = ena;
        if (ena && bus.x_valid) state_nxt = MAC;
      end
      MAC:  if (ena && last) state_nxt = OUT;
      OUT: begin
        bus.y_valid = 1'b1;
        if (ena && bus.y_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
      acc <= '0;
      k   <= '0;
      y_q <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (coef_ok) c[bus.coef_addr] <= bus.coef_data;
          // clr wipes history; a sample accepted in the same cycle still lands in d[0]
          if (accept) begin
            d[0] <= bus.x_in;
            for (int i = 1; i < TAPS; i++) d[i] <= clr ? '0 : d[i-1];
            acc <= '0;
            k   <= '0;
          end else if (clr) begin
            for (int i = 0; i < TAPS; i++) d[i] <= '0;
          end
        end
        MAC: begin
          acc <= sum_nxt;
          if (last) begin
            k   <= '0;
            y_q <= sat(sum_nxt);
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fir_mac_filter.md
# fir_mac_filter

Parametrised, time-multiplexed FIR filter: a TAPS-deep signed sample delay line and a writable coefficient bank, with one shared multiply-accumulate unit iterated over all taps per input sample. It is the successor of the single-tap delay/multiply-add block and replaces a chain of those cells with one MAC and a control FSM. Samples enter and results leave through valid/ready handshakes, so the filter sits directly between the sample source and the downstream datapath.

## Interface
- N, 32: sample, coefficient and output width, signed two's complement.
- TAPS, 8: filter length, ≥2.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation, 0..2N-1.
- ACC_W, 2*N+$clog2(TAPS): accumulator width (derived, not overridden).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  global enable; low freezes all state.
- clr  in  1  synchronous clear of the delay line (coefficients kept).
- coef_wr  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index to write.
- coef_data  in  N  signed coefficient.
- x_valid  in  1  input sample valid.
- x_ready  out  1  filter can accept a sample.
- x_in  in  N  signed input sample.
- y_valid  out  1  output sample valid.
- y_ready  in  1  downstream accepts output.
- y_out  out  N  signed, shifted, saturated result.

## Operation
- State: delay line d[0..TAPS-1], coefficients c[0..TAPS-1], acc (ACC_W), tap index k, FSM {IDLE, MAC, OUT}.
- Reset: all d, c, acc, k = 0; FSM = IDLE; y_valid = 0; y_out = 0; x_ready = 1 once rst deasserts.
- x_ready = ena && (state == IDLE). y_valid = (state == OUT), held regardless of ena.
- IDLE: on x_valid && x_ready: d[0] <= x_in, d[i] <= d[i-1]; acc <= 0; k <= 0; -> MAC.
- MAC: each enabled cycle acc <= acc + d[k]*c[k] (full-precision signed); k++; after k == TAPS-1 is accumulated -> OUT, y_out registered from the final sum.
- OUT: y_out = sat_N(acc >>> SHIFT) (clamp to [-2^(N-1), 2^(N-1)-1]); on y_valid && y_ready && ena -> IDLE.
- Coefficient write: accepted only when state == IDLE and ena; c[coef_addr] <= coef_data. Writes in MAC/OUT, or with coef_addr ≥ TAPS, are ignored.
- Write and sample accept in the same IDLE cycle: both take effect; the new coefficient is used for that sample.
- clr: in IDLE zeroes d next cycle; if x_valid is accepted in the same cycle, d[0] = x_in and others 0. clr in MAC/OUT is ignored.
- ena low: no register changes (FSM, k, acc, d, c), no handshake completes, x_ready = 0.
- Result = Σ c[i]·x[n-i], with x[n] being the newest sample at d[0].

## Timing
- Sample accepted at edge t; MAC occupies cycles t+1..t+TAPS; y_valid high from cycle t+TAPS+1 (latency TAPS+1 with ena high).
- Minimum spacing between accepted samples: TAPS+2 cycles (accept, TAPS MAC, OUT handshake); x_ready low throughout MAC and OUT.
- y_out and y_valid are registered and stable while y_valid && !y_ready.
- rst mid-operation: immediate return to reset values; partial result discarded, no y_valid.

## Test plan
- Impulse (N=8, TAPS=4, SHIFT=0, c={1,2,3,4}): x = 1,0,0,0,0 -> y = 1,2,3,4,0, each valid TAPS+1 cycles after accept.
- Saturation: c all 127, four x=127 -> fourth y = 127; c all 127, x=-128 repeated -> y = -128 from the second output on; SHIFT=8 with sum 64516 -> y = 127 (252 clamped).
- Backpressure: hold y_ready=0 for 10 cycles in OUT -> y_out stable, x_ready=0, no sample lost; release -> IDLE next cycle.
- Coefficient writes: write c[1]=5 during MAC -> ignored; coef_addr=TAPS with non-power-of-two TAPS=5 -> no change; write plus accept in the same IDLE cycle -> new value used.
- Reset mid-MAC at k=2: rst asserted asynchronously -> y_valid=0 and y_out=0 immediately, c and d cleared, x_ready=1 after release.
- ena stall: drop ena for 3 cycles inside MAC -> k and acc frozen, latency grows by exactly 3, result unchanged; clr in IDLE -> previous history gone, impulse test re-passes.
